if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the NOP/HALT encodings, the fetch-state enum, the 16-bit address type
// and a small opcode helper. There are no ports; if_stage and if_id_reg import it.
package if_stage_pkg;

    typedef logic [15:0] addr_t;

    // ADD R0,R0,R0 -- harmless because R0 always reads as zero.
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  HLT_OP    = 4'b1111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:12] == HLT_OP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   stall               hold every field
//   flush               load a NOP bubble; overrides stall; pc_out is kept
//   instr_in, pc_in     fetched word and its PC+1
//   instr, valid, pc_out  registered contents
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] instr_in,
    input  addr_t       pc_in,
    output logic [15:0] instr,
    output logic        valid,
    output addr_t       pc_out
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr  <= NOP_INSTR;
            valid  <= 1'b0;
            pc_out <= 16'h0000;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!stall) begin
            instr  <= instr_in;
            valid  <= 1'b1;
            pc_out <= pc_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (RUN/BUBBLE/HALTED),
// IF/ID register instance and decoded field slices.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   hazard                   stall from the decode hazard unit
//   pc_redirect, pc_target   downstream-resolved redirect and target
//   im_addr / im_data        instruction-memory address (= PC) and its word
//   instr_valid              IF/ID holds a real instruction
//   cntrl_opcode .. call_target  slices of the IF/ID instruction
//   PC_out                   PC+1 of the instruction in IF/ID
//   PC_update                high for the cycle after an accepted redirect
//   halted                   FSM is in HALTED
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        pc_redirect,
    input  addr_t       pc_target,
    output addr_t       im_addr,
    input  logic [15:0] im_data,
    output logic        instr_valid,
    output logic [3:0]  cntrl_opcode,
    output logic [3:0]  reg_rs,
    output logic [3:0]  reg_rt_arith,
    output logic [3:0]  arith_imm,
    output logic [3:0]  load_save_reg,
    output logic [2:0]  branch_cond,
    output logic [7:0]  load_save_imm,
    output logic [11:0] call_target,
    output addr_t       PC_out,
    output logic        PC_update,
    output logic        halted
);

    fetch_state_e state, state_nxt;
    addr_t        pc, pc_nxt, pc_inc;
    logic [15:0]  instr;
    logic         fetch_hlt;
    logic         flush;

    assign pc_inc    = pc + 16'd1;   // wraps FFFF -> 0000
    assign fetch_hlt = is_halt(im_data);
    assign im_addr   = pc;

    // In HALTED the pipe drains to bubbles, but a hazard stall still freezes IF/ID.
    assign flush = pc_redirect || (state == HALTED && !hazard);

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .stall    (hazard),
        .flush    (flush),
        .instr_in (im_data),
        .pc_in    (pc_inc),
        .instr    (instr),
        .valid    (instr_valid),
        .pc_out   (PC_out)
    );

    // State and PC register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            pc    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next-state / next-PC
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (pc_redirect) begin
            state_nxt = BUBBLE;
            pc_nxt    = pc_target;
        end else begin
            unique case (state)
                RUN, BUBBLE: begin
                    // BUBBLE lasts one cycle even if the fetch itself is stalled.
                    state_nxt = RUN;
                    if (!hazard) begin
                        if (fetch_hlt) begin
                            state_nxt = HALTED;   // PC parks on the HLT word
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end
                HALTED: state_nxt = HALTED;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Outputs
    always_comb begin
        PC_update = (state == BUBBLE);
        halted    = (state == HALTED);
    end

    assign cntrl_opcode  = instr[15:12];
    assign load_save_reg = instr[11:8];
    assign branch_cond   = instr[10:8];
    assign reg_rs        = instr[7:4];
    assign reg_rt_arith  = instr[3:0];
    assign arith_imm     = instr[3:0];
    assign load_save_imm = instr[7:0];
    assign call_target   = instr[11:0];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, hazard, pc_redirect;
    logic [15:0] pc_target, im_addr, im_data, PC_out;
    logic        instr_valid, PC_update, halted;
    logic [3:0]  cntrl_opcode, reg_rs, reg_rt_arith, arith_imm, load_save_reg;
    logic [2:0]  branch_cond;
    logic [7:0]  load_save_imm;
    logic [11:0] call_target;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .hazard(hazard), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .im_addr(im_addr), .im_data(im_data),
        .instr_valid(instr_valid), .cntrl_opcode(cntrl_opcode), .reg_rs(reg_rs),
        .reg_rt_arith(reg_rt_arith), .arith_imm(arith_imm),
        .load_save_reg(load_save_reg), .branch_cond(branch_cond),
        .load_save_imm(load_save_imm), .call_target(call_target),
        .PC_out(PC_out), .PC_update(PC_update), .halted(halted)
    );

    typedef struct {
        logic        rst, hz, rd;
        logic [15:0] tgt, dat;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ins, pco;
        logic        upd, hlt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic h, logic d, logic [15:0] t, logic [15:0] im,
                                logic [15:0] a, logic v, logic [15:0] i, logic [15:0] p,
                                logic u, logic hl);
        vec_t x;
        x.rst = r; x.hz = h; x.rd = d; x.tgt = t; x.dat = im;
        x.addr = a; x.vld = v; x.ins = i; x.pco = p; x.upd = u; x.hlt = hl;
        return x;
    endfunction

    task automatic check(input string name, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic drive(input logic r, input logic h, input logic d,
                         input logic [15:0] t, input logic [15:0] im);
        rst = r; hazard = h; pc_redirect = d; pc_target = t; im_data = im;
    endtask

    initial begin
        logic [15:0] got_ins;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        //            rst hz rd  tgt      im_data  | addr     vld ins      pc_out   upd hlt
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0)); // 0 reset
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0)); // 1
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h1234, 16'h0001, 1, 16'h1234, 16'h0001, 0, 0)); // 2 first fetch
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h2001, 16'h0002, 1, 16'h2001, 16'h0002, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h3002, 16'h0003, 1, 16'h3002, 16'h0003, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h4003, 16'h0004, 1, 16'h4003, 16'h0004, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h5004, 16'h0005, 1, 16'h5004, 16'h0005, 0, 0)); // 6 PC=5
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h6005, 16'h0005, 1, 16'h5004, 16'h0005, 0, 0)); // 7 stall x3
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h6005, 16'h0005, 1, 16'h5004, 16'h0005, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h6005, 16'h0005, 1, 16'h5004, 16'h0005, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h6005, 16'h0006, 1, 16'h6005, 16'h0006, 0, 0)); // 10 resume
        tbl.push_back(mk(1, 1, 1, 16'h0040, 16'h7006, 16'h0040, 0, 16'h0000, 16'h0006, 1, 0)); // 11 redirect+hazard
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h8040, 16'h0041, 1, 16'h8040, 16'h0041, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hF000, 16'h0041, 1, 16'hF000, 16'h0042, 0, 1)); // 13 HLT
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hF000, 16'h0041, 0, 16'h0000, 16'h0042, 0, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h1111, 16'h0041, 0, 16'h0000, 16'h0042, 0, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h1111, 16'h0041, 0, 16'h0000, 16'h0042, 0, 1)); // 16 hazard in HALTED
        tbl.push_back(mk(1, 0, 1, 16'h0010, 16'h1111, 16'h0010, 0, 16'h0000, 16'h0042, 1, 0)); // 17 exit halt
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h9010, 16'h0011, 1, 16'h9010, 16'h0011, 0, 0));
        tbl.push_back(mk(1, 0, 1, 16'hFFFF, 16'h9011, 16'hFFFF, 0, 16'h0000, 16'h0011, 1, 0)); // 19
        tbl.push_back(mk(1, 0, 1, 16'h0020, 16'h9011, 16'h0020, 0, 16'h0000, 16'h0011, 1, 0)); // 20 redirect in BUBBLE
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h9020, 16'h0020, 0, 16'h0000, 16'h0011, 0, 0)); // 21 hazard in BUBBLE
        tbl.push_back(mk(1, 0, 1, 16'hFFFF, 16'h9020, 16'hFFFF, 0, 16'h0000, 16'h0011, 1, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hA0FF, 16'h0000, 1, 16'hA0FF, 16'h0000, 0, 0)); // 23 wrap
        tbl.push_back(mk(1, 0, 1, 16'h0030, 16'hA000, 16'h0030, 0, 16'h0000, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0055, 16'hA030, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0)); // 25 reset in BUBBLE
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hF000, 16'h0000, 1, 16'hF000, 16'h0001, 0, 1)); // 26
        tbl.push_back(mk(0, 0, 1, 16'h0077, 16'hF000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0)); // 27 reset in HALTED
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hB000, 16'h0001, 1, 16'hB000, 16'h0001, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'hF000, 16'h0001, 1, 16'hB000, 16'h0001, 0, 0)); // 29 HLT+hazard
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'hF000, 16'h0001, 1, 16'hF000, 16'h0002, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].hz, tbl[i].rd, tbl[i].tgt, tbl[i].dat);
            @(posedge clk);
            #1;
            got_ins = {cntrl_opcode, load_save_reg, reg_rs, reg_rt_arith};
            check("im_addr",     i, im_addr,             tbl[i].addr);
            check("instr_valid", i, {15'd0, instr_valid}, {15'd0, tbl[i].vld});
            check("ifid_instr",  i, got_ins,             tbl[i].ins);
            check("PC_out",      i, PC_out,              tbl[i].pco);
            check("PC_update",   i, {15'd0, PC_update},  {15'd0, tbl[i].upd});
            check("halted",      i, {15'd0, halted},     {15'd0, tbl[i].hlt});
        end

        // Field slicing: reset, fetch 16'h1234, inspect every decoded field.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h1234);
        @(posedge clk); #1;
        im_data = 16'hFFFF;   // IF/ID must not follow im_data combinationally
        #1;
        check("cntrl_opcode",  100, {12'd0, cntrl_opcode},  16'h0001);
        check("reg_rs",        100, {12'd0, reg_rs},        16'h0003);
        check("reg_rt_arith",  100, {12'd0, reg_rt_arith},  16'h0004);
        check("arith_imm",     100, {12'd0, arith_imm},     16'h0004);
        check("load_save_reg", 100, {12'd0, load_save_reg}, 16'h0002);
        check("branch_cond",   100, {13'd0, branch_cond},   16'h0002);
        check("load_save_imm", 100, {8'd0, load_save_imm},  16'h0034);
        check("call_target",   100, {4'd0, call_target},    16'h0234);
        check("PC_out",        100, PC_out,                 16'h0001);
        check("im_addr",       100, im_addr,                16'h0001);

        // Redirect pulse: PC_update high for exactly one cycle.
        drive(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
        @(posedge clk); #1;
        check("pulse_hi",  101, {15'd0, PC_update}, 16'h0001);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222);
        @(posedge clk); #1;
        check("pulse_lo",  101, {15'd0, PC_update}, 16'h0000);
        check("pulse_pc",  101, im_addr,            16'h0101);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
